aes_key_schedule_seq: RTL and testbench
=======================================

Name: aes_key_schedule_seq

Overview:
- Sequential AES key-expansion engine; successor to the single-round combinational key step.
- Generates the full round-key sequence for AES-128, AES-192 or AES-256, one 32-bit word per cycle, selected at run time.
- Packs words into 128-bit round keys and emits them on a valid/ready stream feeding the cipher datapath or a round-key RAM.
- Uses the existing 32-bit combinational key-expansion S-box block: one instance, fed either RotWord(temp) or temp.

Parameters:
- EN_192, default 1: AES-192 support. 0 = mode 2'b01 rejected.
- EN_256, default 1: AES-256 support. 0 = mode 2'b10 rejected.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request; accepted when start && !busy.
- mode  in  2  00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = illegal.
- key_in  in  256  cipher key, word0 = key_in[255:224]; only the top 32*Nk bits are used.
- busy  out  1  high from the accepting edge until the final round key is accepted.
- err  out  1  one-cycle pulse when a start is rejected.
- out_valid  out  1  round key available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_key  out  128  round key, word 4r+0 in [127:96].
- out_round  out  4  round index r, 0..Nr.
- out_last  out  1  high with round key Nr.

Behaviour:
- Reset: busy=0, err=0, out_valid=0, out_key=0, out_round=0, out_last=0. All internal state cleared. RST mid-operation aborts immediately; no further output.
- Start acceptance:
  - Mode latched, key latched into the Nk-word window, word index i=0, rcon register=8'h01.
  - start while busy is ignored.
  - mode=11, or a mode disabled by parameter: err pulses the next cycle, busy stays 0.
- States: IDLE -> GEN (on accept) -> DRAIN (all 4*(Nr+1) words produced; waiting for the final key to be accepted) -> IDLE.
- GEN, one word per advancing edge (i = 0 .. 4*(Nr+1)-1):
  - i<Nk: w[i] = key word i.
  - i>=Nk: temp = w[i-1]. If i mod Nk == 0, w[i] = w[i-Nk] ^ SubWord(RotWord(temp)) ^ {rcon,24'h0}, and rcon then advances by GF(2^8) xtime (80 -> 1b). Else if Nk==8 and i mod 8 == 4, w[i] = w[i-Nk] ^ SubWord(temp). Else w[i] = w[i-Nk] ^ temp.
  - Window of the last Nk words (max 8 x 32) shifts each produced word.
- Packing: words are collected in a 3-word holding register plus a position counter. On the 4th word, {h0,h1,h2,w} loads out_key, out_valid is set, out_round increments (first round key is 0), and out_last = (round==Nr).
- Backpressure: generation advances in a cycle unless (out_valid && !out_ready && position==3). Words at positions 0..2 may proceed while the output is held. out_key is stable while out_valid && !out_ready.
- out_valid clears on acceptance unless a new key loads on the same edge.
- Latency with out_ready held high: round key 0 is valid after the 4th edge following the accept edge; subsequent keys follow every 4 cycles. Final key arrives at edge 44, 52 or 60.
- busy falls on the edge that accepts out_last. start is accepted on the following cycle at the earliest.
- out_round width: 4 bits suffices for values up to 14.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with out_last=1; exactly 11 beats; busy low after the last beat.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round 1 = 62f8ead2522c6b7bfe0c91f72402f5a5; last word w51 = 01002202; 13 beats.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round 2 = 9ba354118e6925afa51a8b5f2067fcde; w12 = a8b09c1a (SubWord-only step); w59 = 706c631e; 15 beats.
- AES-128 vector with out_ready randomly toggled (50%), plus one 20-cycle stall -> identical 11 keys in order, out_key stable during every stall, no key dropped or duplicated.
- mode=11, then mode=01 with EN_192=0 -> err single-cycle pulse each time, busy=0, out_valid=0. start asserted while busy -> ignored, sequence unaffected.
- RST asserted at round 5 of AES-256 -> all outputs 0 the next cycle; a new AES-128 start then yields the correct vector from round 0.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_key_sbox32
// Purpose  : Applies the AES S-box to each byte of a 32-bit word (SubWord).
//            Purely combinational.
// Ports    : din  [31:0]  input word
//            dout [31:0]  byte-wise S-box substitution of din
// Revision : 1.0  initial release
// ============================================================================
module aes_key_sbox32 (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Row-major table, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  generate
    for (genvar b = 0; b < 4; b++) begin : g_byte
      // Entry x sits at bit offset 8*(255-x); 255-x == ~x for an 8-bit x.
      assign dout[8*b +: 8] = SBOX[{~din[8*b +: 8], 3'b000} +: 8];
    end
  endgenerate

endmodule

// ============================================================================
// Module   : aes_key_schedule_seq
// Purpose  : Sequential AES-128/192/256 key expansion. Produces one 32-bit
//            key word per cycle, packs four words into a 128-bit round key
//            and delivers round keys on a valid/ready stream.
// Ports    : CLK        clock, rising edge
//            RST        synchronous active-high reset
//            start      request, accepted when start && !busy
//            mode [1:0] 00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//            key_in[255:0] cipher key, word 0 in [255:224]
//            busy       high from accept until the final key is taken
//            err        one-cycle pulse when a start is rejected
//            out_valid / out_ready  round-key handshake
//            out_key[127:0]  round key, first word in [127:96]
//            out_round[3:0]  round index 0..Nr
//            out_last   marks round key Nr
// Revision : 1.0  initial release
// ============================================================================
module aes_key_schedule_seq #(
  parameter logic EN_192 = 1'b1,
  parameter logic EN_256 = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         mode_q;
  // Window of previous words, newest in win[0], w[i-Nk] in win[Nk-1].
  logic [7:0][31:0]   win;
  logic [5:0]         idx;
  logic [2:0]         kpos;      // i mod Nk
  logic [7:0]         rcon;
  logic [2:0][31:0]   hold;      // hold[2] is the oldest pending word
  logic [1:0]         pos;
  logic [3:0]         round_cnt;

  logic [3:0]         nk;
  logic [3:0]         nr;
  logic [5:0]         last_idx;
  logic [31:0]        w_old;
  logic [31:0]        temp;
  logic [31:0]        sbox_in;
  logic [31:0]        sbox_out;
  logic [31:0]        word_new;
  logic [255:0]       key_aligned;
  logic               in_key_phase;
  logic               rot_step;
  logic               sub_step;
  logic               mode_bad;
  logic               advance;
  logic               accept_out;

  always_comb begin
    nk       = 4'd8;
    nr       = 4'd14;
    last_idx = 6'd59;
    w_old    = win[7];
    case (mode_q)
      2'b00: begin nk = 4'd4; nr = 4'd10; last_idx = 6'd43; w_old = win[3]; end
      2'b01: begin nk = 4'd6; nr = 4'd12; last_idx = 6'd51; w_old = win[5]; end
      default: begin end
    endcase
  end

  // Key words land so that key word 0 is at win[Nk-1]. While i < Nk the
  // engine emits win[Nk-1] and shifts it back in, which rotates the key
  // through the window and leaves it in the correct order after Nk steps.
  always_comb begin
    case (mode)
      2'b00:   key_aligned = {128'h0, key_in[255:128]};
      2'b01:   key_aligned = {64'h0,  key_in[255:64]};
      default: key_aligned = key_in;
    endcase
  end

  assign temp         = win[0];
  assign in_key_phase = (idx < {2'b00, nk});
  assign rot_step     = !in_key_phase && (kpos == 3'd0);
  assign sub_step     = !in_key_phase && (mode_q == 2'b10) && (kpos == 3'd4);
  assign sbox_in      = (kpos == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

  aes_key_sbox32 u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  always_comb begin
    if (in_key_phase)  word_new = w_old;
    else if (rot_step) word_new = w_old ^ sbox_out ^ {rcon, 24'h0};
    else if (sub_step) word_new = w_old ^ sbox_out;
    else               word_new = w_old ^ temp;
  end

  assign mode_bad   = (mode == 2'b11) || ((mode == 2'b01) && !EN_192) ||
                      ((mode == 2'b10) && !EN_256);
  assign accept_out = out_valid && out_ready;
  // Only the word that would complete a new round key must wait for the
  // consumer; earlier words go into the holding register.
  assign advance    = (state == S_GEN) && !(out_valid && !out_ready && (pos == 2'd3));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      mode_q    <= 2'b00;
      win       <= '0;
      idx       <= 6'd0;
      kpos      <= 3'd0;
      rcon      <= 8'h00;
      hold      <= '0;
      pos       <= 2'd0;
      round_cnt <= 4'd0;
      busy      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_key   <= 128'h0;
      out_round <= 4'd0;
      out_last  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept_out) out_valid <= 1'b0;   // a load below takes priority

      case (state)
        S_IDLE: begin
          if (start) begin
            if (mode_bad) begin
              err <= 1'b1;
            end else begin
              mode_q    <= mode;
              win       <= key_aligned;
              idx       <= 6'd0;
              kpos      <= 3'd0;
              rcon      <= 8'h01;
              pos       <= 2'd0;
              round_cnt <= 4'd0;
              busy      <= 1'b1;
              state     <= S_GEN;
            end
          end
        end

        S_GEN: begin
          if (advance) begin
            win <= {win[6:0], word_new};
            idx <= idx + 6'd1;
            if ({1'b0, kpos} == nk - 4'd1) kpos <= 3'd0;
            else                           kpos <= kpos + 3'd1;
            if (rot_step) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

            if (pos == 2'd3) begin
              out_key   <= {hold[2], hold[1], hold[0], word_new};
              out_valid <= 1'b1;
              out_round <= round_cnt;
              out_last  <= (round_cnt == nr);
              round_cnt <= round_cnt + 4'd1;
              pos       <= 2'd0;
            end else begin
              hold <= {hold[1:0], word_new};
              pos  <= pos + 2'd1;
            end

            if (idx == last_idx) state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (accept_out && out_last) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_schedule_seq
// Purpose  : Directed self-checking bench for aes_key_schedule_seq using the
//            FIPS-197 key-expansion vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_key_schedule_seq;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start, start2;
  logic [1:0]   mode, mode2;
  logic [255:0] key_in;
  logic         out_ready;
  logic         busy, err, out_valid, out_last;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         busy2, err2, out_valid2, out_last2;
  logic [127:0] out_key2;
  logic [3:0]   out_round2;

  always #5 CLK = ~CLK;

  aes_key_schedule_seq u_dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .err(err), .out_valid(out_valid), .out_ready(out_ready),
    .out_key(out_key), .out_round(out_round), .out_last(out_last)
  );

  aes_key_schedule_seq #(.EN_192(1'b0), .EN_256(1'b1)) u_dut_no192 (
    .CLK(CLK), .RST(RST), .start(start2), .mode(mode2), .key_in(key_in),
    .busy(busy2), .err(err2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_key(out_key2), .out_round(out_round2), .out_last(out_last2)
  );

  localparam logic [127:0] K128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int total = 0;
  int bad   = 0;

  logic [127:0] cap_key   [0:15];
  logic [3:0]   cap_round [0:15];
  logic         cap_last  [0:15];
  int           nbeats, first_t, last_t;
  logic [31:0]  word_chk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts one expansion and collects every accepted beat. rnd toggles
  // out_ready randomly; stall_at opens a 20-cycle stall; poke_at raises a
  // start while busy. Also verifies out_key holds during every stall.
  task automatic run_seq(input logic [1:0] m, input logic [255:0] k,
                         input bit rnd, input int stall_at, input int poke_at);
    bit           held;
    bit           done;
    logic [127:0] prev;
    nbeats = 0; first_t = -1; last_t = -1;
    held = 1'b0; done = 1'b0; prev = '0;
    mode = m; key_in = k; out_ready = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (t >= stall_at && t < stall_at + 20) out_ready = 1'b0;
      if (t == poke_at) begin
        start = 1'b1; mode = 2'b00; key_in = ~k;
      end else begin
        start = 1'b0;
      end
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_key", out_key, prev);
      end
      if (out_valid && first_t < 0) first_t = t;
      if (out_valid && out_ready) begin
        if (nbeats < 16) begin
          cap_key[nbeats]   = out_key;
          cap_round[nbeats] = out_round;
          cap_last[nbeats]  = out_last;
        end
        nbeats++;
        if (out_last) begin
          last_t = t;
          done   = 1'b1;
        end
      end
      held = out_valid && !out_ready;
      prev = out_key;
      @(negedge CLK);
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!done) chk("seq_timeout", 0, 1);
    chk("busy_after_last", busy, 0);
    chk("valid_after_last", out_valid, 0);
  endtask

  task automatic chk_aes128_all(input string tag);
    chk({tag, "_beats"}, nbeats, 11);
    for (int r = 0; r < 11; r++) begin
      chk($sformatf("%s_key%0d", tag, r), cap_key[r], K128[r]);
      chk($sformatf("%s_round%0d", tag, r), cap_round[r], r);
      chk($sformatf("%s_last%0d", tag, r), cap_last[r], (r == 10));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit found;
    RST = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'b00; mode2 = 2'b00;
    key_in = '0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_key", out_key, 0);
    chk("rst_round", out_round, 0);
    chk("rst_last", out_last, 0);
    RST = 1'b0;
    @(negedge CLK);

    // AES-128, ready held high: full sequence and latency
    run_seq(2'b00, KEY128, 1'b0, -100, -1);
    chk_aes128_all("a128");
    chk("a128_first_latency", first_t, 4);
    chk("a128_last_latency", last_t, 44);

    // AES-192 with a start raised while busy
    run_seq(2'b01, KEY192, 1'b0, -100, 10);
    chk("a192_beats", nbeats, 13);
    chk("a192_r0", cap_key[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    chk("a192_r1", cap_key[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    word_chk = cap_key[12][31:0];
    chk("a192_w51", word_chk, 32'h01002202);
    chk("a192_last12", cap_last[12], 1);
    chk("a192_last11", cap_last[11], 0);
    chk("a192_round12", cap_round[12], 12);
    chk("a192_last_latency", last_t, 52);

    // AES-256
    run_seq(2'b10, KEY256, 1'b0, -100, -1);
    chk("a256_beats", nbeats, 15);
    chk("a256_r0", cap_key[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("a256_r1", cap_key[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("a256_r2", cap_key[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    word_chk = cap_key[3][127:96];
    chk("a256_w12", word_chk, 32'ha8b09c1a);
    word_chk = cap_key[14][31:0];
    chk("a256_w59", word_chk, 32'h706c631e);
    chk("a256_round14", cap_round[14], 14);
    chk("a256_last14", cap_last[14], 1);
    chk("a256_last_latency", last_t, 60);

    // AES-128 with random backpressure and a long stall
    run_seq(2'b00, KEY128, 1'b1, 15, -1);
    chk_aes128_all("a128bp");

    // Illegal mode
    mode = 2'b11; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_valid", out_valid, 0);
    @(negedge CLK);
    chk("ill_err_clear", err, 0);

    // AES-192 on an instance built without it
    mode2 = 2'b01; start2 = 1'b1;
    @(negedge CLK);
    start2 = 1'b0;
    chk("no192_err", err2, 1);
    chk("no192_busy", busy2, 0);
    chk("no192_valid", out_valid2, 0);
    @(negedge CLK);
    chk("no192_err_clear", err2, 0);
    chk("no192_busy_later", busy2, 0);

    // Reset during AES-256 round 5
    mode = 2'b10; key_in = KEY256; out_ready = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      if (out_valid && out_round == 4'd5) found = 1'b1;
      else @(negedge CLK);
    end
    chk("abort_reach_r5", found, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_key", out_key, 0);
    chk("abort_round", out_round, 0);
    chk("abort_last", out_last, 0);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    chk("abort_quiet_valid", out_valid, 0);
    chk("abort_quiet_busy", busy, 0);

    run_seq(2'b00, KEY128, 1'b0, -100, -1);
    chk_aes128_all("a128post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
